// File: rtl/booth_pkg.sv
// booth_pkg: shared constants, output-side state encoding and sign-extension
// helper for the Booth dot-product accumulator slice.
// Optional feature macro used by this slice: BOOTH_ACC_SAT_EN.
package booth_pkg;

   // Product width of the 4x4 signed Booth multiplier (2 x operand width).
   localparam int PROD_W_DEF = 8;

   // Output register occupancy.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Sign-extend the low w bits of v to 64 bits; callers truncate to ACC_W.
   function automatic logic [63:0] sign_ext(input logic [63:0] v, input int unsigned w);
      logic signed [63:0] r;
      r = $signed(v << (64 - w));
      return r >>> (64 - w);
   endfunction

endpackage

// File: rtl/booth_dot_accum_if.sv
// booth_dot_accum_if: product input, control and sum output bundle for
// booth_dot_accum. master = producer/consumer side, slave = accumulator.
interface booth_dot_accum_if #(
   parameter int PROD_W  = booth_pkg::PROD_W_DEF,
   parameter int ACC_W   = 12,
   parameter int VEC_LEN = 4
);
   localparam int CNT_W = $clog2(VEC_LEN + 1);

   logic                     prod_valid;
   logic signed [PROD_W-1:0] prod;
   logic                     clear;
   logic                     sum_valid;
   logic                     sum_ready;
   logic signed [ACC_W-1:0]  sum;
   logic                     sum_sat;
   logic                     overrun;
   logic [CNT_W-1:0]         count;

   modport master (
      output prod_valid, prod, clear, sum_ready,
      input  sum_valid, sum, sum_sat, overrun, count
   );

   modport slave (
      input  prod_valid, prod, clear, sum_ready,
      output sum_valid, sum, sum_sat, overrun, count
   );

endinterface

// File: rtl/booth_sat_add.sv
// booth_sat_add: combinational ACC_W signed adder. With BOOTH_ACC_SAT_EN
// defined it detects signed overflow and clamps to the representable range;
// otherwise it wraps modulo 2^ACC_W and reports no overflow.
module booth_sat_add #(
   parameter int ACC_W = 12
) (
   input  logic signed [ACC_W-1:0] a_i,
   input  logic signed [ACC_W-1:0] b_i,
   output logic signed [ACC_W-1:0] y_o,
   output logic                    ovf_o
);

   logic signed [ACC_W-1:0] raw;

   // Plain modular sum.
   always_comb raw = a_i + b_i;

`ifdef BOOTH_ACC_SAT_EN
   logic ovf;

   // Overflow: operands agree in sign but the sum does not; clamp toward that sign.
   always_comb begin
      ovf = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
      y_o = raw;
      if (ovf) begin
         y_o = a_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   assign ovf_o = ovf;
`else
   assign y_o   = raw;
   assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/booth_dot_accum.sv
// booth_dot_accum: accumulates VEC_LEN consecutive Booth products into an
// ACC_W signed dot product and presents it on a one-deep valid/ready
// register. Products are never stalled; a completed sum that finds the
// output register full is dropped and flagged in the sticky overrun bit.
// Optional feature macro: BOOTH_ACC_SAT_EN (saturating adds, sum_sat flag).
module booth_dot_accum
   import booth_pkg::*;
#(
   parameter int PROD_W  = PROD_W_DEF,
   parameter int ACC_W   = 12,
   parameter int VEC_LEN = 4
) (
   input logic              clk,
   input logic              rst,
   booth_dot_accum_if.slave bus
);

   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sat_q, sat_d;
   out_state_t              out_q, out_d;
   logic signed [ACC_W-1:0] sum_q, sum_d;
   logic                    sum_sat_q, sum_sat_d;
   logic                    ovr_q, ovr_d;

   logic signed [ACC_W-1:0] ext_prod;
   logic signed [ACC_W-1:0] add_y;
   logic                    add_ovf;
   logic                    last;
   logic                    pop;

   // Bring the product up to accumulator width.
   always_comb ext_prod = ACC_W'(sign_ext({{(64-PROD_W){1'b0}}, bus.prod}, PROD_W));

   booth_sat_add #(.ACC_W(ACC_W)) u_add (
      .a_i   (acc_q),
      .b_i   (ext_prod),
      .y_o   (add_y),
      .ovf_o (add_ovf)
   );

   assign last = (cnt_q == LAST_CNT);
   assign pop  = (out_q == OUT_FULL) && bus.sum_ready;

   // Next state: clear beats everything; a completion may refill in the cycle it is popped.
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      out_d     = out_q;
      sum_d     = sum_q;
      sum_sat_d = sum_sat_q;
      ovr_d     = ovr_q;
      if (bus.clear) begin
         acc_d     = '0;
         cnt_d     = '0;
         sat_d     = 1'b0;
         out_d     = OUT_EMPTY;
         sum_sat_d = 1'b0;
         ovr_d     = 1'b0;
      end else begin
         if (pop) out_d = OUT_EMPTY;
         if (bus.prod_valid) begin
            if (last) begin
               acc_d = '0;
               cnt_d = '0;
               sat_d = 1'b0;
               if ((out_q == OUT_EMPTY) || pop) begin
                  sum_d     = add_y;
                  sum_sat_d = sat_q | add_ovf;
                  out_d     = OUT_FULL;
               end else begin
                  ovr_d = 1'b1;
               end
            end else begin
               acc_d = add_y;
               cnt_d = cnt_q + CNT_W'(1);
               sat_d = sat_q | add_ovf;
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         out_q     <= OUT_EMPTY;
         sum_q     <= '0;
         sum_sat_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         out_q     <= out_d;
         sum_q     <= sum_d;
         sum_sat_q <= sum_sat_d;
         ovr_q     <= ovr_d;
      end
   end

   assign bus.sum_valid = (out_q == OUT_FULL);
   assign bus.sum       = sum_q;
   assign bus.sum_sat   = sum_sat_q;
   assign bus.overrun   = ovr_q;
   assign bus.count     = cnt_q;

endmodule

// File: tb/tb_booth_dot_accum.sv
// tb_booth_dot_accum: directed bench for booth_dot_accum. Instance a is the
// default build (ACC_W=12, VEC_LEN=4), b narrows ACC_W to 9 for the
// saturation/wrap boundary, c uses VEC_LEN=1.
// Expected values for b depend on BOOTH_ACC_SAT_EN.
module tb_booth_dot_accum;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   booth_dot_accum_if                           a_if ();
   booth_dot_accum_if #(.ACC_W(9))              b_if ();
   booth_dot_accum_if #(.VEC_LEN(1))            c_if ();

   booth_dot_accum                 dut_a (.clk(clk), .rst(rst), .bus(a_if));
   booth_dot_accum #(.ACC_W(9))    dut_b (.clk(clk), .rst(rst), .bus(b_if));
   booth_dot_accum #(.VEC_LEN(1))  dut_c (.clk(clk), .rst(rst), .bus(c_if));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pa(input int v);
      a_if.prod_valid = 1'b1;
      a_if.prod       = 8'(v);
      step();
      a_if.prod_valid = 1'b0;
   endtask

   task automatic pb(input int v);
      b_if.prod_valid = 1'b1;
      b_if.prod       = 8'(v);
      step();
      b_if.prod_valid = 1'b0;
   endtask

   task automatic pc(input int v);
      c_if.prod_valid = 1'b1;
      c_if.prod       = 8'(v);
      step();
      c_if.prod_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_if.prod_valid = 1'b0; a_if.prod = '0; a_if.clear = 1'b0; a_if.sum_ready = 1'b0;
      b_if.prod_valid = 1'b0; b_if.prod = '0; b_if.clear = 1'b0; b_if.sum_ready = 1'b1;
      c_if.prod_valid = 1'b0; c_if.prod = '0; c_if.clear = 1'b0; c_if.sum_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("init_valid", {31'd0, a_if.sum_valid}, 32'd0);
      chk("init_count", {29'd0, a_if.count}, 32'd0);

      // Reset held two cycles in the middle of a vector
      pa(3); pa(4);
      chk("mid_count", {29'd0, a_if.count}, 32'd2);
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_valid", {31'd0, a_if.sum_valid}, 32'd0);
      chk("rst_sum", {20'd0, a_if.sum}, 32'h000);
      chk("rst_count", {29'd0, a_if.count}, 32'd0);
      chk("rst_ovr", {31'd0, a_if.overrun}, 32'd0);
      chk("rst_sat", {31'd0, a_if.sum_sat}, 32'd0);

      // Basic dot product with idle gaps 1, 3, 0
      a_if.sum_ready = 1'b1;
      pa(10); step();
      pa(-20); step(); step(); step();
      pa(64);
      chk("basic_pre_valid", {31'd0, a_if.sum_valid}, 32'd0);
      chk("basic_pre_count", {29'd0, a_if.count}, 32'd3);
      pa(5);
      chk("basic_valid", {31'd0, a_if.sum_valid}, 32'd1);
      chk("basic_sum", {20'd0, a_if.sum}, 32'h03B);
      chk("basic_count", {29'd0, a_if.count}, 32'd0);
      chk("basic_sat", {31'd0, a_if.sum_sat}, 32'd0);
      step();
      chk("basic_popped", {31'd0, a_if.sum_valid}, 32'd0);
      chk("basic_sum_kept", {20'd0, a_if.sum}, 32'h03B);

      // Backpressure and overrun
      a_if.sum_ready = 1'b0;
      pa(1); pa(1); pa(1); pa(1);
      chk("bp_valid", {31'd0, a_if.sum_valid}, 32'd1);
      chk("bp_sum", {20'd0, a_if.sum}, 32'h004);
      pa(2); pa(2); pa(2); pa(2);
      chk("ovr_flag", {31'd0, a_if.overrun}, 32'd1);
      chk("ovr_sum_held", {20'd0, a_if.sum}, 32'h004);
      chk("ovr_valid_held", {31'd0, a_if.sum_valid}, 32'd1);
      a_if.sum_ready = 1'b1;
      step();
      chk("ovr_popped", {31'd0, a_if.sum_valid}, 32'd0);
      chk("ovr_sticky", {31'd0, a_if.overrun}, 32'd1);
      a_if.sum_ready = 1'b0;
      a_if.clear = 1'b1;
      step();
      a_if.clear = 1'b0;
      chk("clr_ovr", {31'd0, a_if.overrun}, 32'd0);

      // Pop coincident with completion
      pa(1); pa(1); pa(1); pa(1);
      chk("pc_pending", {20'd0, a_if.sum}, 32'h004);
      pa(-3); pa(-3); pa(-3);
      a_if.sum_ready = 1'b1;
      pa(-3);
      chk("pc_sum", {20'd0, a_if.sum}, 32'hFF4);
      chk("pc_valid", {31'd0, a_if.sum_valid}, 32'd1);
      chk("pc_ovr", {31'd0, a_if.overrun}, 32'd0);
      step();
      chk("pc_popped", {31'd0, a_if.sum_valid}, 32'd0);

      // Clear mid-vector, coincident with a product
      pa(7); pa(7);
      a_if.clear = 1'b1;
      pa(9);
      a_if.clear = 1'b0;
      chk("cm_count", {29'd0, a_if.count}, 32'd0);
      chk("cm_valid", {31'd0, a_if.sum_valid}, 32'd0);
      pa(1); pa(2); pa(3);
      chk("cm_pre_valid", {31'd0, a_if.sum_valid}, 32'd0);
      pa(4);
      chk("cm_sum", {20'd0, a_if.sum}, 32'h00A);
      chk("cm_valid2", {31'd0, a_if.sum_valid}, 32'd1);
      step();

      // Clear discards a pending output
      a_if.sum_ready = 1'b0;
      pa(1); pa(1); pa(1); pa(1);
      chk("cp_pending", {31'd0, a_if.sum_valid}, 32'd1);
      a_if.clear = 1'b1;
      step();
      a_if.clear = 1'b0;
      chk("cp_valid", {31'd0, a_if.sum_valid}, 32'd0);

      // Width boundary on the 9-bit accumulator
      pb(64); pb(64); pb(64); pb(64);
      chk("w9_valid", {31'd0, b_if.sum_valid}, 32'd1);
`ifdef BOOTH_ACC_SAT_EN
      chk("w9_sum", {23'd0, b_if.sum}, 32'h0FF);
      chk("w9_sat", {31'd0, b_if.sum_sat}, 32'd1);
`else
      chk("w9_sum", {23'd0, b_if.sum}, 32'h100);
      chk("w9_sat", {31'd0, b_if.sum_sat}, 32'd0);
`endif
      step();
      pb(1); pb(1); pb(1); pb(1);
      chk("w9_next_sum", {23'd0, b_if.sum}, 32'h004);
      chk("w9_next_sat", {31'd0, b_if.sum_sat}, 32'd0);

      // VEC_LEN=1: every product completes
      pc(5);
      chk("v1_valid", {31'd0, c_if.sum_valid}, 32'd1);
      chk("v1_sum", {20'd0, c_if.sum}, 32'h005);
      chk("v1_count", {31'd0, c_if.count}, 32'd0);
      pc(-2);
      chk("v1_sum2", {20'd0, c_if.sum}, 32'hFFE);
      step();
      chk("v1_popped", {31'd0, c_if.sum_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
